// File: rtl/cobra_step_pkg.sv
// Shared types and constants for the CYBERcobra core clock stepper.
package cobra_step_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } step_state_t;

  localparam int RATE_BASE_DEFAULT = 10;
  localparam int STEP_CNT_W        = 16;
  localparam int RATE_W            = 4;

  // Period counter must hold 2**(rate_base + max rate) without overflow.
  function automatic int per_cnt_width(input int rate_base);
    return rate_base + (1 << RATE_W);
  endfunction

endpackage

// File: rtl/cobra_step_ctrl_rise_detect.sv
// Rising-edge detector for an already synchronised, debounced level.
module rise_detect (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  // Previous-cycle copy of the level.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/cobra_step_ctrl.sv
// Core clock generator: single-step or free-run pulse train from debounced buttons.
// Optional breakpoint halt enabled by defining COBRA_STEP_BREAKPOINT_EN.
module cobra_step_ctrl
  import cobra_step_pkg::*;
#(
  parameter int PULSE_CYCLES = 50,
  parameter int ADDR_W       = 32,
  parameter int RATE_BASE    = RATE_BASE_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  step_i,
  input  logic                  run_i,
  input  logic [RATE_W-1:0]     rate_i,
  input  logic                  bp_en_i,
  input  logic [ADDR_W-1:0]     bp_addr_i,
  input  logic [ADDR_W-1:0]     instr_addr_i,
  output logic                  cpu_clk_o,
  output logic                  running_o,
  output logic                  halted_o,
  output logic [STEP_CNT_W-1:0] step_cnt_o
);

  localparam int PW    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int PER_W = per_cnt_width(RATE_BASE);
  localparam logic [PW-1:0]    PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [PW-1:0]    PULSE_ONE  = PW'(1'b1);
  localparam logic [PER_W-1:0] PER_ONE    = PER_W'(1'b1);
  localparam logic [STEP_CNT_W-1:0] CNT_ONE = STEP_CNT_W'(1'b1);

  step_state_t             state_q, state_d;
  logic [PW-1:0]           pulse_cnt_q, pulse_cnt_d;
  logic [PER_W-1:0]        per_cnt_q, per_cnt_d;
  logic [PER_W-1:0]        per_tgt_s;
  logic                    running_q, running_d;
  logic                    halted_q, halted_d;
  logic                    cpu_clk_q, cpu_clk_d;
  logic [STEP_CNT_W-1:0]   step_cnt_q, step_cnt_d;
  logic                    step_rise_s, run_rise_s;
  logic                    pulse_last_s, issue_s, bp_hit_s;

  rise_detect u_step_rise (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .level_i (step_i),
    .rise_o  (step_rise_s)
  );

  rise_detect u_run_rise (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .level_i (run_i),
    .rise_o  (run_rise_s)
  );

  assign per_tgt_s    = (PER_ONE << (RATE_BASE + int'(rate_i))) - PER_ONE;
  assign pulse_last_s = (pulse_cnt_q == PULSE_LAST);

  // A run toggle in the same cycle suppresses any issue, so a coincident step is dropped.
  assign issue_s = (state_q == IDLE) & ~run_rise_s &
                   ((step_rise_s & ~running_q) | (running_q & (per_cnt_q >= per_tgt_s)));

`ifdef COBRA_STEP_BREAKPOINT_EN
  assign bp_hit_s = (state_q == LOW) & pulse_last_s & running_q & bp_en_i &
                    (instr_addr_i == bp_addr_i);
`else
  logic unused_bp_s;
  assign unused_bp_s = ^{bp_en_i, bp_addr_i, instr_addr_i};
  assign bp_hit_s    = 1'b0;
`endif

  // Pulse FSM: next state, in-phase counter and registered clock level.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    case (state_q)
      IDLE: begin
        if (issue_s) begin
          state_d     = HIGH;
          pulse_cnt_d = '0;
        end else begin
          state_d     = IDLE;
        end
      end
      HIGH: begin
        if (pulse_last_s) begin
          state_d     = LOW;
          pulse_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PULSE_ONE;
        end
      end
      LOW: begin
        if (pulse_last_s) begin
          state_d     = IDLE;
          pulse_cnt_d = '0;
        end else begin
          pulse_cnt_d = pulse_cnt_q + PULSE_ONE;
        end
      end
      default: begin
        state_d     = IDLE;
        pulse_cnt_d = '0;
      end
    endcase
    cpu_clk_d = (state_d == HIGH);
  end

  // Run/halt flags, free-run period counter and issued-pulse counter.
  always_comb begin
    running_d  = running_q;
    halted_d   = halted_q;
    per_cnt_d  = per_cnt_q;
    step_cnt_d = step_cnt_q;

    if (bp_hit_s) begin
      running_d = 1'b0;
      halted_d  = 1'b1;
    end else if (run_rise_s) begin
      running_d = ~running_q;
      halted_d  = 1'b0;
    end else if (step_rise_s) begin
      halted_d  = 1'b0;
    end else begin
      halted_d  = halted_q;
    end

    // Saturating at the live target lets a lowered rate fire at the next IDLE.
    if (run_rise_s || issue_s) begin
      per_cnt_d = '0;
    end else if (running_q && (per_cnt_q < per_tgt_s)) begin
      per_cnt_d = per_cnt_q + PER_ONE;
    end else if (running_q) begin
      per_cnt_d = per_tgt_s;
    end else begin
      per_cnt_d = per_cnt_q;
    end

    if (issue_s) begin
      step_cnt_d = step_cnt_q + CNT_ONE;
    end else begin
      step_cnt_d = step_cnt_q;
    end
  end

  // State and output registers; reset drops the core clock immediately.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
      per_cnt_q   <= '0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      cpu_clk_q   <= 1'b0;
      step_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      per_cnt_q   <= per_cnt_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
      cpu_clk_q   <= cpu_clk_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  assign cpu_clk_o  = cpu_clk_q;
  assign running_o  = running_q;
  assign halted_o   = halted_q;
  assign step_cnt_o = step_cnt_q;

endmodule

// File: tb/tb_cobra_step_ctrl.sv
// Self-checking bench for cobra_step_ctrl: directed vectors, scenario sequences and random stimulus.
`timescale 1ns/1ps
module tb_cobra_step_ctrl;

  localparam int P  = 4;
  localparam int RB = 4;
  localparam int AW = 32;

  logic          clk_i = 1'b0;
  logic          arstn_i, step_i, run_i, bp_en_i;
  logic [3:0]    rate_i;
  logic [AW-1:0] bp_addr_i, instr_addr_i;
  logic          cpu_clk_o, running_o, halted_o;
  logic [15:0]   step_cnt_o;

  cobra_step_ctrl #(.PULSE_CYCLES(P), .ADDR_W(AW), .RATE_BASE(RB)) dut (
    .clk_i        (clk_i),
    .arstn_i      (arstn_i),
    .step_i       (step_i),
    .run_i        (run_i),
    .rate_i       (rate_i),
    .bp_en_i      (bp_en_i),
    .bp_addr_i    (bp_addr_i),
    .instr_addr_i (instr_addr_i),
    .cpu_clk_o    (cpu_clk_o),
    .running_o    (running_o),
    .halted_o     (halted_o),
    .step_cnt_o   (step_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        step;
    logic        run;
    logic [3:0]  rate;
    logic        e_clk;
    logic        e_run;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [13];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pulse age in cycles since issue (-1 = no pulse in flight).
  int          m_age;
  bit          m_run, m_halt, m_ps, m_pr;
  int          m_per;
  logic [15:0] m_cnt;

  int cyc, rise_cnt, last_rise, rise_gap, hi_run, last_hi, pc_base, s, c0;
  bit last_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_age = -1; m_run = 0; m_halt = 0; m_ps = 0; m_pr = 0; m_per = 0; m_cnt = 16'd0;
  endtask

  task automatic model_step();
    bit sr, rr, idle, issue, bp;
    int tgt;
    sr = step_i && !m_ps;
    rr = run_i && !m_pr;
    m_ps = step_i;
    m_pr = run_i;
    tgt = (1 << (RB + int'(rate_i))) - 1;
    idle = (m_age < 0);
    issue = idle && !rr && ((sr && !m_run) || (m_run && m_per >= tgt));
    bp = 0;
`ifdef COBRA_STEP_BREAKPOINT_EN
    bp = (m_age == 2*P-1) && m_run && bp_en_i && (instr_addr_i == bp_addr_i);
`endif
    if (rr || issue) m_per = 0;
    else if (m_run) m_per = (m_per + 1 > tgt) ? tgt : m_per + 1;
    if (bp) begin
      m_run = 0; m_halt = 1;
    end else begin
      if (rr) m_run = !m_run;
      if (sr || rr) m_halt = 0;
    end
    if (issue) begin
      m_age = 0; m_cnt = m_cnt + 16'd1;
    end else if (m_age >= 0) begin
      m_age++;
      if (m_age == 2*P) m_age = -1;
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
    cyc++;
    check("cpu_clk", {31'd0, cpu_clk_o}, (m_age >= 0 && m_age < P) ? 32'd1 : 32'd0);
    check("running", {31'd0, running_o}, {31'd0, m_run});
    check("halted", {31'd0, halted_o}, {31'd0, m_halt});
    check("step_cnt", {16'd0, step_cnt_o}, {16'd0, m_cnt});
    if (cpu_clk_o && !last_clk) begin
      rise_cnt++;
      rise_gap = cyc - last_rise;
      last_rise = cyc;
    end
    if (cpu_clk_o) hi_run++;
    else if (last_clk) begin
      last_hi = hi_run; hi_run = 0;
    end
    last_clk = cpu_clk_o;
    instr_addr_i = AW'((rise_cnt - pc_base) * 4);
  endtask

  task automatic wait_rise(input int max, input string name);
    int start;
    bit got;
    start = rise_cnt;
    got = 0;
    for (int i = 0; i < max && !got; i++) begin
      tick();
      if (rise_cnt != start) got = 1;
    end
    check(name, {31'd0, got}, 32'd1);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 16'd1};
    tbl[2]  = '{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 16'd1};
    tbl[3]  = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 16'd1};
    tbl[4]  = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 16'd1};
    tbl[5]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'd1};
    tbl[6]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'd1};
    tbl[7]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'd1};
    tbl[8]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'd1};
    tbl[9]  = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 16'd1};
    tbl[10] = '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 16'd1};
    tbl[11] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 16'd2};
    tbl[12] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 16'd2};

    arstn_i = 1'b0; step_i = 1'b0; run_i = 1'b0; rate_i = 4'd0;
    bp_en_i = 1'b0; bp_addr_i = '0; instr_addr_i = '0;
    cyc = 0; rise_cnt = 0; last_rise = 0; rise_gap = 0; hi_run = 0; last_hi = 0;
    pc_base = 0; last_clk = 0;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_clk", {31'd0, cpu_clk_o}, 32'd0);
    check("rst_running", {31'd0, running_o}, 32'd0);
    check("rst_halted", {31'd0, halted_o}, 32'd0);
    check("rst_cnt", {16'd0, step_cnt_o}, 32'd0);
    arstn_i = 1'b1;

    // Single steps, a step dropped mid-HIGH, and a second step after LOW.
    for (int i = 0; i < 13; i++) begin
      step_i = tbl[i].step; run_i = tbl[i].run; rate_i = tbl[i].rate;
      tick();
      check("vec_clk", {31'd0, cpu_clk_o}, {31'd0, tbl[i].e_clk});
      check("vec_running", {31'd0, running_o}, {31'd0, tbl[i].e_run});
      check("vec_cnt", {16'd0, step_cnt_o}, {16'd0, tbl[i].e_cnt});
    end
    repeat (100) tick();
    check("hold_rises", rise_cnt, 32'd2);
    check("hold_pulse_len", last_hi, P);
    check("hold_cnt", {16'd0, step_cnt_o}, 32'd2);
    step_i = 1'b0;
    tick();

    // Free run at rate 0, then stop mid-HIGH.
    rate_i = 4'd0; run_i = 1'b1; c0 = cyc;
    wait_rise(40, "run_first_timeout");
    check("run_first_gap", cyc - (c0 + 1), 32'd16);
    run_i = 1'b0;
    wait_rise(40, "run2_timeout");
    check("run_gap2", rise_gap, 32'd16);
    wait_rise(40, "run3_timeout");
    check("run_gap3", rise_gap, 32'd16);
    run_i = 1'b1;
    s = rise_cnt;
    repeat (100) tick();
    check("stop_no_more", rise_cnt, s);
    check("stop_pulse_len", last_hi, P);
    check("stop_running", {31'd0, running_o}, 32'd0);
    run_i = 1'b0;
    tick();

    // Rate change during run.
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    wait_rise(40, "r4_first_timeout");
    rate_i = 4'd2;
    wait_rise(100, "r4_a_timeout");
    check("rate2_gap_a", rise_gap, 32'd64);
    wait_rise(100, "r4_b_timeout");
    check("rate2_gap_b", rise_gap, 32'd64);
    run_i = 1'b1; tick(); run_i = 1'b0;
    repeat (12) tick();
    check("r4_stopped", {31'd0, running_o}, 32'd0);
    rate_i = 4'd0;

    // Breakpoint at PC 0x0C.
    pc_base = rise_cnt; instr_addr_i = '0; bp_addr_i = 32'h0000_000C; bp_en_i = 1'b1;
    s = rise_cnt;
    run_i = 1'b1; tick(); run_i = 1'b0;
    repeat (120) tick();
`ifdef COBRA_STEP_BREAKPOINT_EN
    check("bp_pulses", rise_cnt - s, 32'd3);
    check("bp_running", {31'd0, running_o}, 32'd0);
    check("bp_halted", {31'd0, halted_o}, 32'd1);
    step_i = 1'b1; tick();
    check("bp_halt_clr", {31'd0, halted_o}, 32'd0);
    step_i = 1'b0;
    repeat (20) tick();
    check("bp_step_pulses", rise_cnt - s, 32'd4);
    check("bp_step_running", {31'd0, running_o}, 32'd0);
`else
    check("nobp_pulses", rise_cnt - s, 32'd7);
    check("nobp_running", {31'd0, running_o}, 32'd1);
    check("nobp_halted", {31'd0, halted_o}, 32'd0);
    run_i = 1'b1; tick(); run_i = 1'b0;
    repeat (20) tick();
    check("nobp_stopped", {31'd0, running_o}, 32'd0);
`endif
    bp_en_i = 1'b0;

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) step_i = ~step_i;
      if ($urandom_range(0, 63) == 0) run_i = ~run_i;
      if ($urandom_range(0, 199) == 0) rate_i = 4'($urandom_range(0, 2));
      if ($urandom_range(0, 99) == 0) begin
        bp_en_i = 1'($urandom_range(0, 1));
        bp_addr_i = AW'(4 * $urandom_range(0, 15));
        pc_base = rise_cnt - int'($urandom_range(0, 8));
      end
      tick();
    end

    // Asynchronous reset in the middle of a HIGH phase.
    step_i = 1'b0; run_i = 1'b0; rate_i = 4'd0; bp_en_i = 1'b0;
    tick();
    if (!running_o) begin
      run_i = 1'b1; tick(); run_i = 1'b0;
    end
    wait_rise(40, "rst_pre_timeout");
    #2 arstn_i = 1'b0;
    #1;
    check("arst_clk", {31'd0, cpu_clk_o}, 32'd0);
    check("arst_running", {31'd0, running_o}, 32'd0);
    check("arst_halted", {31'd0, halted_o}, 32'd0);
    check("arst_cnt", {16'd0, step_cnt_o}, 32'd0);
    model_reset();
    @(posedge clk_i);
    #1;
    check("arst_hold_clk", {31'd0, cpu_clk_o}, 32'd0);
    arstn_i = 1'b1;
    last_clk = 1'b0; hi_run = 0;
    repeat (20) tick();
    step_i = 1'b1;
    tick();
    check("post_rst_clk", {31'd0, cpu_clk_o}, 32'd1);
    check("post_rst_cnt", {16'd0, step_cnt_o}, 32'd1);
    step_i = 1'b0;
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
